line_fill_unit: RTL and testbench

- Sits directly downstream of the L1 cache and consumes its READ_OUT miss requests, which carry a 26-bit line address.
- Queues misses, merges duplicates, fetches each line from next-level memory as a 16-beat burst, and returns the assembled 512-bit line to the cache with a valid/ready handshake.
- Keeps fill and merge statistics for the end-of-run report.

---
 rtl/line_fill_unit_pkg.sv | 42 ++++
 rtl/line_fill_unit_if.sv | 36 +++
 rtl/line_fill_unit_miss_queue.sv | 69 ++++++
 rtl/line_fill_unit.sv | 127 ++++++++++++
 tb/tb_line_fill_unit.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/line_fill_unit_pkg.sv
// line_fill_unit_pkg
//   Shared types and constants for the L1 line fill path: line/byte address
//   types, the assembled line type, the fill FSM state encoding and the cache
//   command codes that accompany miss traffic.
package line_fill_unit_pkg;

  localparam int ADDRBITS         = 32;
  localparam int LINE_OFFSET_BITS = 6;
  localparam int LINEADDRBITS     = ADDRBITS - LINE_OFFSET_BITS;
  localparam int WORDBITS         = 32;
  localparam int BEATS_PER_LINE   = 16;
  localparam int BEATS            = BEATS_PER_LINE;
  localparam int BEATCNTBITS      = $clog2(BEATS);

  typedef logic bool_t;

  // Command codes carried by cache requests; misses arrive as READ_OUT.
  typedef enum logic [1:0] {
    READ_IN   = 2'd0,
    READ_OUT  = 2'd1,
    WRITE_IN  = 2'd2,
    WRITE_OUT = 2'd3
  } cache_cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    BEAT,
    DELIVER
  } fill_state_t;

  typedef logic [LINEADDRBITS-1:0]     line_addr_t;
  typedef logic [ADDRBITS-1:0]         byte_addr_t;
  typedef logic [WORDBITS-1:0]         word_t;
  typedef logic [BEATS*WORDBITS-1:0]   line_data_t;

  // Byte address of the first byte of a line.
  function automatic byte_addr_t line_base(input line_addr_t a);
    return {a, {LINE_OFFSET_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/line_fill_unit_if.sv
// line_fill_unit_if
//   Bundles the three handshakes around the fill unit:
//     miss_*  : cache -> fill unit miss requests (valid/ready)
//     mem_*   : fill unit <-> next-level memory (req/ack, then rvalid beats)
//     fill_*  : fill unit -> cache assembled line (valid/ready)
//   master : the line fill unit itself
//   slave  : the surrounding cache and memory
interface line_fill_unit_if;
  import line_fill_unit_pkg::*;

  logic       miss_valid;
  line_addr_t miss_addr;
  logic       miss_ready;

  logic       mem_req;
  byte_addr_t mem_addr;
  logic       mem_ack;
  logic       mem_rvalid;
  word_t      mem_rdata;

  logic       fill_valid;
  line_addr_t fill_addr;
  line_data_t fill_data;
  logic       fill_ready;

  modport master (
    input  miss_valid, miss_addr, mem_ack, mem_rvalid, mem_rdata, fill_ready,
    output miss_ready, mem_req, mem_addr, fill_valid, fill_addr, fill_data
  );

  modport slave (
    output miss_valid, miss_addr, mem_ack, mem_rvalid, mem_rdata, fill_ready,
    input  miss_ready, mem_req, mem_addr, fill_valid, fill_addr, fill_data
  );

endinterface

// File: rtl/line_fill_unit_miss_queue.sv
// miss_queue
//   QDEPTH-entry FIFO of pending miss line addresses plus a combinational
//   match vector of cmp_addr against every currently valid entry.
//   Ports: clock, reset_n (async, active-low); push/push_addr; pop;
//          head_addr (oldest entry); empty/full; cmp_addr -> match_vec.
//   A push while full or a pop while empty is ignored.
module miss_queue
  import line_fill_unit_pkg::*;
#(
  parameter int QDEPTH = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              push,
  input  line_addr_t        push_addr,
  input  logic              pop,
  output line_addr_t        head_addr,
  output logic              empty,
  output logic              full,
  input  line_addr_t        cmp_addr,
  output logic [QDEPTH-1:0] match_vec
);

  localparam int PTRBITS = $clog2(QDEPTH);

  logic [PTRBITS-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PTRBITS:0]   count_reg;
  line_addr_t         entry_reg [QDEPTH];
  logic               do_push, do_pop;

  assign empty     = (count_reg == '0);
  assign full      = (count_reg == (PTRBITS+1)'(QDEPTH));
  assign do_push   = push & ~full;
  assign do_pop    = pop & ~empty;
  assign head_addr = entry_reg[rd_ptr_reg];

  // Pointers wrap naturally because QDEPTH is a power of two.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Entry storage needs no reset: validity comes from the pointers/count.
  always_ff @(posedge clock) begin
    if (do_push) entry_reg[wr_ptr_reg] <= push_addr;
  end

  // An entry is valid when its distance from the read pointer is below count.
  genvar gi;
  generate
    for (gi = 0; gi < QDEPTH; gi++) begin : g_match
      logic [PTRBITS-1:0] rel;
      assign rel           = PTRBITS'(gi) - rd_ptr_reg;
      assign match_vec[gi] = ({1'b0, rel} < count_reg) && (entry_reg[gi] == cmp_addr);
    end
  endgenerate

endmodule

// File: rtl/line_fill_unit.sv
// line_fill_unit
//   Accepts L1 READ_OUT misses, drops duplicates (counted in merged), queues
//   the rest, fetches one line at a time as a BEATS-beat burst and hands the
//   assembled line back to the cache.
//   Ports: clock, reset_n (async, active-low); bus (line_fill_unit_if.master:
//          miss, memory and fill handshakes); fills_done, merged (wrapping
//          counters); proto_err (sticky, read beat seen outside a burst).
module line_fill_unit
  import line_fill_unit_pkg::*;
#(
  parameter int QDEPTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  line_fill_unit_if.master bus,
  output logic [31:0]      fills_done,
  output logic [31:0]      merged,
  output logic             proto_err
);

  fill_state_t            state_reg, state_next;
  line_addr_t             cur_addr_reg;
  logic [BEATCNTBITS-1:0] beat_cnt_reg;
  logic [31:0]            fills_done_reg, merged_reg;
  logic                   proto_err_reg;
  word_t                  word_reg [BEATS];
  line_data_t             fill_line;

  line_addr_t             q_head;
  logic                   q_empty, q_full;
  logic [QDEPTH-1:0]      q_match;
  bool_t                  miss_fire, cur_hit, dup_hit, q_push, q_pop;
  bool_t                  beat_fire, last_beat;

  // Ready is low while reset is held so that every output reads 0 in reset.
  assign bus.miss_ready = reset_n & ~q_full;
  assign miss_fire      = bus.miss_valid & bus.miss_ready;
  // The line being fetched or delivered also counts as an outstanding miss.
  assign cur_hit        = (state_reg != IDLE) && (bus.miss_addr == cur_addr_reg);
  assign dup_hit        = (|q_match) | cur_hit;
  assign q_push         = miss_fire & ~dup_hit;
  assign beat_fire      = (state_reg == BEAT) && bus.mem_rvalid;
  assign last_beat      = beat_fire && (beat_cnt_reg == BEATCNTBITS'(BEATS-1));

  miss_queue #(.QDEPTH(QDEPTH)) u_queue (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (q_push),
    .push_addr (bus.miss_addr),
    .pop       (q_pop),
    .head_addr (q_head),
    .empty     (q_empty),
    .full      (q_full),
    .cmp_addr  (bus.miss_addr),
    .match_vec (q_match)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next     = state_reg;
    q_pop          = 1'b0;
    bus.mem_req    = 1'b0;
    bus.fill_valid = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!q_empty) begin
          q_pop      = 1'b1;
          state_next = REQ;
        end
      end
      REQ: begin
        bus.mem_req = 1'b1;
        if (bus.mem_ack) state_next = BEAT;
      end
      BEAT: begin
        if (last_beat) state_next = DELIVER;
      end
      DELIVER: begin
        bus.fill_valid = 1'b1;
        if (bus.fill_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cur_addr_reg   <= '0;
      beat_cnt_reg   <= '0;
      fills_done_reg <= '0;
      merged_reg     <= '0;
      proto_err_reg  <= 1'b0;
    end else begin
      if (q_pop) cur_addr_reg <= q_head;
      if ((state_reg == REQ) && bus.mem_ack) beat_cnt_reg <= '0;
      else if (beat_fire)                    beat_cnt_reg <= beat_cnt_reg + 1'b1;
      if ((state_reg == DELIVER) && bus.fill_ready) fills_done_reg <= fills_done_reg + 32'd1;
      if (miss_fire && dup_hit) merged_reg <= merged_reg + 32'd1;
      // Beats outside a burst (including leftovers of a burst cut by reset)
      // are dropped and flagged.
      if (bus.mem_rvalid && (state_reg != BEAT)) proto_err_reg <= 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < BEATS; gi++) begin : g_line
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                                         word_reg[gi] <= '0;
        else if (beat_fire && (beat_cnt_reg == BEATCNTBITS'(gi))) word_reg[gi] <= bus.mem_rdata;
      end
      assign fill_line[gi*WORDBITS +: WORDBITS] = word_reg[gi];
    end
  endgenerate

  assign bus.mem_addr  = line_base(cur_addr_reg);
  assign bus.fill_addr = cur_addr_reg;
  assign bus.fill_data = fill_line;
  assign fills_done    = fills_done_reg;
  assign merged        = merged_reg;
  assign proto_err     = proto_err_reg;

endmodule

// File: tb/tb_line_fill_unit.sv
// tb_line_fill_unit
//   Drives misses into line_fill_unit, models a next-level memory whose beat
//   k of line A is exp_word(A, k), and checks every delivered line against a
//   scoreboard filled when the misses are issued.
module tb_line_fill_unit;
  import line_fill_unit_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] fills_done, merged;
  logic        proto_err;

  line_fill_unit_if bus ();

  line_fill_unit #(.QDEPTH(4)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .bus        (bus),
    .fills_done (fills_done),
    .merged     (merged),
    .proto_err  (proto_err)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic word_t exp_word(input line_addr_t a, input int k);
    return 32'hA000_0000 | (32'(a ^ 26'h123) << 8) | 32'(k);
  endfunction

  function automatic line_data_t exp_line(input line_addr_t a);
    line_data_t l;
    for (int k = 0; k < BEATS; k++) l[k*WORDBITS +: WORDBITS] = exp_word(a, k);
    return l;
  endfunction

  typedef struct {
    line_addr_t addr;
    line_data_t data;
  } fill_exp_t;

  fill_exp_t  sb[$];
  fill_exp_t  mon_exp;

  bit         mem_enable = 1'b1;
  int         ack_delay = 0;
  int         beat_gap = 0;
  bit         fill_hold = 1'b0;
  int         req_count = 0;
  bit         mem_busy = 1'b0;
  int         mem_beat_idx = -1;
  byte_addr_t req_a;
  byte_addr_t last_req_addr = '0;
  int         accept_cyc = 0;
  int         fill_rise_cyc = 0;
  line_data_t last_fill_data = '0;
  bit         fv_prev = 1'b0;

  // Next-level memory: answers one request at a time.
  initial begin : mem_model
    bus.mem_ack    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    forever begin
      @(negedge clock);
      if (mem_enable && (bus.mem_req === 1'b1)) begin
        mem_beat_idx  = -1;
        mem_busy      = 1'b1;
        req_a         = bus.mem_addr;
        last_req_addr = req_a;
        req_count++;
        $display("mem request addr=%h", req_a);
        for (int d = 0; d < ack_delay; d++) begin
          @(negedge clock);
          check_val("mem_addr_stable", bus.mem_addr, req_a);
          check_val("mem_req_held", bus.mem_req, 1);
        end
        bus.mem_ack = 1'b1;
        @(negedge clock);
        bus.mem_ack = 1'b0;
        check_val("mem_req_drop", bus.mem_req, 0);
        for (int k = 0; k < BEATS; k++) begin
          for (int g = 0; g < beat_gap; g++) @(negedge clock);
          mem_beat_idx   = k;
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = exp_word(req_a[31:6], k);
          @(negedge clock);
          bus.mem_rvalid = 1'b0;
        end
        mem_busy = 1'b0;
      end
    end
  end

  // Cache side: consumes fills and compares against the scoreboard.
  initial begin : fill_mon
    bus.fill_ready = 1'b0;
    forever begin
      @(negedge clock);
      bus.fill_ready = !fill_hold;
      if (bus.fill_valid && !fv_prev) fill_rise_cyc = cyc;
      fv_prev = bus.fill_valid;
      if (bus.fill_valid && bus.fill_ready) begin
        check_val("sb_has_entry", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          mon_exp = sb.pop_front();
          check_val("fill_addr", bus.fill_addr, mon_exp.addr);
          check_val("fill_data", bus.fill_data, mon_exp.data);
        end
        last_fill_data = bus.fill_data;
        $display("fill addr=%h word0=%h word15=%h", bus.fill_addr,
                 bus.fill_data[31:0], bus.fill_data[511:480]);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the transfer edge.
  task automatic send_miss(input line_addr_t a, input bit expect_fill);
    int n = 0;
    bus.miss_valid = 1'b1;
    bus.miss_addr  = a;
    while ((bus.miss_ready !== 1'b1) && (n < 500)) begin
      @(negedge clock);
      n++;
    end
    check_val("miss_accepted", n < 500, 1);
    accept_cyc = cyc;
    if (expect_fill) sb.push_back('{a, exp_line(a)});
    $display("miss addr=%h expect_fill=%0d", a, expect_fill);
    @(negedge clock);
    bus.miss_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((sb.size() != 0 || mem_busy || bus.fill_valid) && (n < 3000)) begin
      @(negedge clock);
      n++;
    end
    check_val(tag, sb.size(), 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int t1_acc, base_req, n, stable, reqs;
    bus.miss_valid = 1'b0;
    bus.miss_addr  = '0;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    check_val("rst_miss_ready", bus.miss_ready, 0);
    check_val("rst_mem_req", bus.mem_req, 0);
    check_val("rst_mem_addr", bus.mem_addr, 0);
    check_val("rst_fill_valid", bus.fill_valid, 0);
    check_val("rst_fill_data", bus.fill_data, 0);
    check_val("rst_fills_done", fills_done, 0);
    check_val("rst_merged", merged, 0);
    check_val("rst_proto_err", proto_err, 0);
    reset_n = 1'b1;
    @(negedge clock);
    check_val("ready_after_rst", bus.miss_ready, 1);

    // Single miss, zero-wait memory.
    send_miss(26'h123, 1'b1);
    t1_acc = accept_cyc;
    wait_drain("t1_drain");
    check_val("t1_mem_addr", last_req_addr, 32'h0000_48C0);
    check_val("t1_latency", fill_rise_cyc - t1_acc, 19);
    check_val("t1_word15", last_fill_data[511:480], 32'hA000_000F);
    check_val("t1_fills_done", fills_done, 1);

    // Five misses with memory stalled: one in flight, four queued, then full.
    mem_enable = 1'b0;
    for (int i = 0; i < 5; i++) send_miss(line_addr_t'(26'h10 + i), 1'b1);
    check_val("t2_full_ready", bus.miss_ready, 0);
    check_val("t2_inflight_addr", bus.mem_addr, {26'h10, 6'b0});
    check_val("t2_mem_req", bus.mem_req, 1);
    bus.miss_valid = 1'b1;
    bus.miss_addr  = 26'h3F;
    repeat (4) @(negedge clock);
    check_val("t2_still_full", bus.miss_ready, 0);
    bus.miss_valid = 1'b0;
    check_val("t2_no_merge", merged, 0);
    repeat (3) @(negedge clock);
    mem_enable = 1'b1;
    wait_drain("t2_drain");
    check_val("t2_fills_done", fills_done, 6);

    // Duplicate of the in-flight line and of a queued line.
    beat_gap = 3;
    base_req = req_count;
    send_miss(26'h55, 1'b1);
    n = 0;
    while (!(mem_busy && mem_beat_idx >= 1) && n < 200) begin
      @(negedge clock);
      n++;
    end
    check_val("t3_in_beat", n < 200, 1);
    send_miss(26'h66, 1'b1);
    send_miss(26'h55, 1'b0);
    send_miss(26'h66, 1'b0);
    check_val("t3_merged", merged, 2);
    wait_drain("t3_drain");
    check_val("t3_bursts", req_count - base_req, 2);
    beat_gap = 0;

    // Back-pressure on the fill: line held stable, next miss waits.
    fill_hold = 1'b1;
    base_req  = req_count;
    send_miss(26'h77, 1'b1);
    n = 0;
    while (bus.fill_valid !== 1'b1 && n < 200) begin
      @(negedge clock);
      n++;
    end
    check_val("t4_fill_seen", n < 200, 1);
    send_miss(26'h78, 1'b1);
    stable = 0;
    reqs   = 0;
    repeat (10) begin
      @(negedge clock);
      if (bus.fill_valid === 1'b1 && bus.fill_addr === 26'h77 &&
          bus.fill_data === exp_line(26'h77)) stable++;
      if (bus.mem_req === 1'b1) reqs++;
    end
    check_val("t4_hold_stable", stable, 10);
    check_val("t4_no_req_in_hold", reqs, 0);
    check_val("t4_one_burst_in_hold", req_count - base_req, 1);
    fill_hold = 1'b0;
    wait_drain("t4_drain");
    check_val("t4_bursts", req_count - base_req, 2);

    // Reset in the middle of a burst.
    beat_gap = 2;
    send_miss(26'h99, 1'b0);
    n = 0;
    while (!(mem_busy && mem_beat_idx >= 7) && n < 300) begin
      @(negedge clock);
      n++;
    end
    check_val("t5_reached_beat7", n < 300, 1);
    #2 reset_n = 1'b0;
    #1;
    check_val("t5_rst_miss_ready", bus.miss_ready, 0);
    check_val("t5_rst_mem_req", bus.mem_req, 0);
    check_val("t5_rst_mem_addr", bus.mem_addr, 0);
    check_val("t5_rst_fill_valid", bus.fill_valid, 0);
    check_val("t5_rst_fill_addr", bus.fill_addr, 0);
    check_val("t5_rst_fill_data", bus.fill_data, 0);
    check_val("t5_rst_fills_done", fills_done, 0);
    check_val("t5_rst_merged", merged, 0);
    check_val("t5_rst_proto_err", proto_err, 0);
    @(negedge clock);
    reset_n = 1'b1;
    n = 0;
    while (mem_busy && n < 300) begin
      @(negedge clock);
      n++;
    end
    check_val("t5_stray_done", n < 300, 1);
    check_val("t5_proto_err", proto_err, 1);
    check_val("t5_no_fill", fills_done, 0);
    beat_gap = 0;
    send_miss(26'hAB, 1'b1);
    wait_drain("t5_drain");
    check_val("t5_fills_done", fills_done, 1);
    check_val("t5_proto_sticky", proto_err, 1);

    // Slow memory: delayed ack and gaps between beats.
    ack_delay = 5;
    beat_gap  = 3;
    send_miss(26'hC3, 1'b1);
    wait_drain("t6_drain");
    check_val("t6_mem_addr", last_req_addr, {26'hC3, 6'b0});
    check_val("t6_fills_done", fills_done, 2);
    ack_delay = 0;
    beat_gap  = 0;

    repeat (5) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
